// File: rtl/conv_accumulator_pkg.sv
// Shared FP32 constants, field struct and accumulator FSM state for the convolution accumulator.
package conv_pkg;

  localparam int unsigned SIGN_W  = 1;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned FP_W    = SIGN_W + EXP_W + FRAC_W;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [FP_W-1:0] FP_NAN  = 32'h7FFF_FFFF;
  localparam logic [FP_W-1:0] FP_PINF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic {
    IDLE,
    ACCUM
  } acc_state_t;

  // Leading-zero count of a 24-bit mantissa (24 when the value is zero).
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/conv_accumulator_if.sv
// Product stream in, window result out; master drives taps, slave is the accumulator.
interface conv_acc_if;

  logic        in_valid;
  logic [31:0] in_data;
  logic        in_exception;
  logic        in_nan;
  logic        flush;
  logic        out_valid;
  logic [31:0] out;
  logic        out_exception;
  logic        out_nan;

  modport master (
    output in_valid, in_data, in_exception, in_nan, flush,
    input  out_valid, out, out_exception, out_nan
  );

  modport slave (
    input  in_valid, in_data, in_exception, in_nan, flush,
    output out_valid, out, out_exception, out_nan
  );

endinterface

// File: rtl/conv_accumulator_fp32_add.sv
// Combinational FP32 adder: truncating alignment and rounding, denormal flush, Inf/NaN propagation.
module fp32_add
  import conv_pkg::*;
(
  input  fp32_t a,
  input  fp32_t b,
  output fp32_t sum_c,
  output logic  nan_c,
  output logic  inf_c
);

  logic        a_nan, b_nan, a_inf, b_inf, swap;
  fp32_t       l, s;
  logic [23:0] ml, ms, ms_sh;
  logic [7:0]  d;
  logic [24:0] sum25;
  logic [4:0]  lz;
  logic [9:0]  e_res;
  logic [22:0] frac_n;

  always_comb begin
    a_nan = (a.exp == 8'(EXP_MAX)) && (a.frac != '0);
    b_nan = (b.exp == 8'(EXP_MAX)) && (b.frac != '0);
    a_inf = (a.exp == 8'(EXP_MAX)) && (a.frac == '0);
    b_inf = (b.exp == 8'(EXP_MAX)) && (b.frac == '0);

    // Larger magnitude goes first so the difference never goes negative.
    swap  = {b.exp, b.frac} > {a.exp, a.frac};
    l     = swap ? b : a;
    s     = swap ? a : b;
    ml    = (l.exp == '0) ? 24'd0 : {1'b1, l.frac};
    ms    = (s.exp == '0) ? 24'd0 : {1'b1, s.frac};
    d     = l.exp - s.exp;
    ms_sh = (d >= 8'd25) ? 24'd0 : (ms >> d);
    sum25 = (l.sign == s.sign) ? ({1'b0, ml} + {1'b0, ms_sh})
                               : ({1'b0, ml} - {1'b0, ms_sh});
    lz    = lzc24(sum25[23:0]);

    if (sum25[24]) begin
      frac_n = sum25[23:1];
      e_res  = {2'b00, l.exp} + 10'd1;
    end else begin
      frac_n = 23'(sum25[22:0] << lz);
      e_res  = {2'b00, l.exp} - {5'b00000, lz};
    end

    sum_c = '0;
    nan_c = 1'b0;
    inf_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b.sign))) begin
      sum_c = FP_NAN;
      nan_c = 1'b1;
    end else if (a_inf || b_inf) begin
      sum_c = {(a_inf ? a.sign : b.sign), FP_PINF[30:0]};
      inf_c = 1'b1;
    end else if ((sum25 == '0) || ($signed(e_res) <= 10'sd0)) begin
      sum_c = '0;
    end else if ($signed(e_res) >= 10'sd255) begin
      sum_c = {l.sign, FP_PINF[30:0]};
      inf_c = 1'b1;
    end else begin
      sum_c = {l.sign, e_res[7:0], frac_n};
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// Per-window FP32 accumulator with one-cycle result pulse and flush.
// Optional CONV_ACC_BIAS_EN adds a bias port used as the window preload.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_TAPS = 9,
  parameter int unsigned CNT_W       = $clog2(KERNEL_TAPS + 1)
) (
  input  logic            clk,
  input  logic            rst,
`ifdef CONV_ACC_BIAS_EN
  input  logic [31:0]     bias,
`endif
  conv_acc_if.slave       acc
);

  acc_state_t       state_q, state_d;
  fp32_t            acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      out_q, out_d;
  logic             out_exc_q, out_exc_d;
  logic             out_nan_q, out_nan_d;
  logic             out_valid_q, out_valid_d;

  fp32_t preload_c, tap_c, add_a_c, sum_c;
  logic  nan_c, inf_c, take_c, last_c;

`ifdef CONV_ACC_BIAS_EN
  assign preload_c = fp32_t'(bias);
`else
  assign preload_c = '0;
`endif

  // Flagged products bypass the mantissa as canonical NaN or signed Inf.
  assign tap_c   = acc.in_nan       ? fp32_t'(FP_NAN)
                 : acc.in_exception ? fp32_t'({acc.in_data[31], FP_PINF[30:0]})
                 : fp32_t'(acc.in_data);
  // Tap 1 adds onto the live preload, so a bias is always sampled fresh.
  assign add_a_c = (state_q == IDLE) ? preload_c : acc_q;
  assign take_c  = acc.in_valid && !acc.flush;
  assign last_c  = take_c && (cnt_q == CNT_W'(KERNEL_TAPS - 1));

  fp32_add u_add (
    .a     (add_a_c),
    .b     (tap_c),
    .sum_c (sum_c),
    .nan_c (nan_c),
    .inf_c (inf_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_exc_q   <= 1'b0;
      out_nan_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_exc_q   <= out_exc_d;
      out_nan_q   <= out_nan_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc.flush || last_c) begin
      state_d = IDLE;
    end else if (take_c) begin
      state_d = ACCUM;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_exc_d   = out_exc_q;
    out_nan_d   = out_nan_q;
    out_valid_d = 1'b0;
    if (acc.flush) begin
      acc_d = preload_c;
      cnt_d = '0;
    end else if (last_c) begin
      out_d       = sum_c;
      out_exc_d   = inf_c;
      out_nan_d   = nan_c;
      out_valid_d = 1'b1;
      acc_d       = preload_c;
      cnt_d       = '0;
    end else if (take_c) begin
      acc_d = sum_c;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign acc.out_valid     = out_valid_q;
  assign acc.out           = out_q;
  assign acc.out_exception = out_exc_q;
  assign acc.out_nan       = out_nan_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench for conv_accumulator: 2-tap vector table plus 9-tap flush/reset/gap sequences.
module tb_conv_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_acc_if if9 ();
  conv_acc_if if2 ();

`ifdef CONV_ACC_BIAS_EN
  logic [31:0] bias;
`endif

  conv_accumulator #(.KERNEL_TAPS(9)) u9 (
    .clk  (clk),
    .rst  (rst),
`ifdef CONV_ACC_BIAS_EN
    .bias (bias),
`endif
    .acc  (if9)
  );

  conv_accumulator #(.KERNEL_TAPS(2)) u2 (
    .clk  (clk),
    .rst  (rst),
`ifdef CONV_ACC_BIAS_EN
    .bias (bias),
`endif
    .acc  (if2)
  );

  typedef struct {
    logic [31:0] a;
    logic        a_exc;
    logic        a_nan;
    logic [31:0] b;
    logic        b_exc;
    logic        b_nan;
    logic [31:0] exp_out;
    logic        exp_exc;
    logic        exp_nan;
  } vec_t;

  vec_t vecs [12];
  int   applied     = 0;
  int   miscompares = 0;
  int   pulses9     = 0;
  int   base;

  always @(negedge clk) if (if9.out_valid) pulses9 <= pulses9 + 1;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [39:0] o9();
    return {5'd0, if9.out_valid, if9.out_exception, if9.out_nan, if9.out};
  endfunction

  function automatic logic [39:0] o2();
    return {5'd0, if2.out_valid, if2.out_exception, if2.out_nan, if2.out};
  endfunction

  function automatic logic [39:0] res(input logic v, input logic e, input logic n, input logic [31:0] d);
    return {5'd0, v, e, n, d};
  endfunction

  task automatic tap9(input logic [31:0] d);
    if9.in_valid = 1'b1;
    if9.in_data  = d;
    @(posedge clk); #1;
    if9.in_valid = 1'b0;
  endtask

  task automatic taps9(input int n);
    for (int k = 0; k < n; k++) tap9(32'h3F80_0000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h3FC00000, 1'b0, 1'b0, 32'h40200000, 1'b0, 1'b0, 32'h40800000, 1'b0, 1'b0};
    vecs[1]  = '{32'h40000000, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[2]  = '{32'h7F800000, 1'b1, 1'b0, 32'hFF800000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[3]  = '{32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b0};
    vecs[4]  = '{32'h7F800000, 1'b1, 1'b0, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vecs[5]  = '{32'h7F000000, 1'b0, 1'b0, 32'h7F000000, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b0};
    vecs[6]  = '{32'h4C000000, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 32'h4C000000, 1'b0, 1'b0};
    vecs[7]  = '{32'h3FFFFFFF, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0, 32'h403FFFFF, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000000, 1'b0, 1'b1, 32'h3F800000, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[9]  = '{32'h3F800001, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0, 32'h34000000, 1'b0, 1'b0};
    vecs[10] = '{32'h00C00000, 1'b0, 1'b0, 32'h80800000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[11] = '{32'hBF800000, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0, 32'hC0000000, 1'b0, 1'b0};

    if9.in_valid = 1'b0; if9.in_data = '0; if9.in_exception = 1'b0; if9.in_nan = 1'b0; if9.flush = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_exception = 1'b0; if2.in_nan = 1'b0; if2.flush = 1'b0;
`ifdef CONV_ACC_BIAS_EN
    bias = 32'h0;
`endif
    rst = 1'b0;
    #12;
    check("reset_u9", o9(), 40'd0);
    check("reset_u2", o2(), 40'd0);
    @(negedge clk) rst = 1'b1;
    idle(1);

    // Nine taps of 1.0, pulse exactly one cycle after the last tap, then hold.
    base = pulses9;
    taps9(9);
    check("sum9", o9(), res(1'b1, 1'b0, 1'b0, 32'h41100000));
    idle(1);
    check("hold9", o9(), res(1'b0, 1'b0, 1'b0, 32'h41100000));

    // Partial window, flush with a concurrent tap, then a gapped full window.
    taps9(5);
    if9.flush = 1'b1; if9.in_valid = 1'b1; if9.in_data = 32'h3F800000;
    @(posedge clk); #1;
    if9.flush = 1'b0; if9.in_valid = 1'b0;
    taps9(3);
    idle(2);
    taps9(6);
    check("flush_sum9", o9(), res(1'b1, 1'b0, 1'b0, 32'h41100000));
    idle(3);
    check("pulse_count_flush", 40'(pulses9 - base), 40'd2);

    // Asynchronous reset mid-window clears outputs immediately.
    base = pulses9;
    taps9(4);
    #2 rst = 1'b0;
    #1 check("async_reset", o9(), 40'd0);
    @(negedge clk) rst = 1'b1;
    idle(1);
    taps9(9);
    check("post_reset_sum9", o9(), res(1'b1, 1'b0, 1'b0, 32'h41100000));
    idle(2);
    check("pulse_count_reset", 40'(pulses9 - base), 40'd1);

`ifdef CONV_ACC_BIAS_EN
    bias = 32'h3F000000;
    taps9(9);
    check("bias_sum9", o9(), res(1'b1, 1'b0, 1'b0, 32'h41180000));
    idle(1);
    bias = 32'h0;
`endif

    // Two-tap windows back to back: tap a of each vector lands in the previous pulse cycle.
    for (int i = 0; i < 12; i++) begin
      if2.in_valid = 1'b1;
      if2.in_data = vecs[i].a; if2.in_exception = vecs[i].a_exc; if2.in_nan = vecs[i].a_nan;
      @(posedge clk); #1;
      if (i > 0) check($sformatf("no_pulse_mid_%0d", i), 40'(if2.out_valid), 40'd0);
      if2.in_data = vecs[i].b; if2.in_exception = vecs[i].b_exc; if2.in_nan = vecs[i].b_nan;
      @(posedge clk); #1;
      check($sformatf("vec_%0d", i), o2(),
            res(1'b1, vecs[i].exp_exc, vecs[i].exp_nan, vecs[i].exp_out));
    end
    if2.in_valid = 1'b0; if2.in_exception = 1'b0; if2.in_nan = 1'b0;
    idle(1);
    check("hold2", o2(), res(1'b0, 1'b0, 1'b0, 32'hC0000000));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
